// File: rtl/approx_mult_pkg.sv
// Shared types and the 4x4 tile reference function for approx_mult_pipe.
// The tile function is also the golden model for approximate tiles.
package approx_mult_pkg;

    localparam int SUB_W = 4;

    typedef enum logic [1:0] {
        MODE_EXACT   = 2'b00,
        MODE_APX_ADD = 2'b01,
        MODE_APX_OR  = 2'b10
    } mode_e;

    // Exact 4x4 product with the low 'trunc' bits forced to zero (trunc=0 gives exact)
    function automatic logic [2*SUB_W-1:0] apx4(input logic [SUB_W-1:0] a,
                                                 input logic [SUB_W-1:0] b,
                                                 input int               trunc);
        logic [2*SUB_W-1:0] prod;
        logic [2*SUB_W-1:0] mask;
        prod = {{SUB_W{1'b0}}, a} * {{SUB_W{1'b0}}, b};
        mask = {(2*SUB_W){1'b1}} << trunc;
        return prod & mask;
    endfunction

endpackage

// File: rtl/sub_mult_4x4.sv
// Combinational 4x4 tile multiplier; apx_en selects the truncated variant.
module sub_mult_4x4
    import approx_mult_pkg::*;
#(
    parameter int TRUNC = 2
) (
    input  logic [SUB_W-1:0]   a,
    input  logic [SUB_W-1:0]   b,
    input  logic               apx_en,
    output logic [2*SUB_W-1:0] p
);

    always_comb begin
        p = apx_en ? apx4(a, b, TRUNC) : apx4(a, b, 0);
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined approximate multiplier built from 4x4 tiles.
// Optional error statistics (out_err, err_cnt) enabled by APPROX_MULT_ERRSTAT_EN.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_r,
    output logic [TAG_W-1:0]   out_tag
`ifdef APPROX_MULT_ERRSTAT_EN
    ,
    output logic               out_err,
    output logic [15:0]        err_cnt
`endif
);

    localparam int NT = WIDTH / SUB_W;
    localparam int PW = 2 * WIDTH;
    localparam int TP = 2 * SUB_W;

    if (((WIDTH % SUB_W) != 0) || (TRUNC > SUB_W) || (TRUNC < 0)) begin : g_bad_param
        $error("approx_mult_pipe: WIDTH must be a multiple of 4 and TRUNC must be 0..4");
    end

    logic adv;

    logic               valid_s1;
    logic [WIDTH-1:0]   a_s1;
    logic [WIDTH-1:0]   b_s1;
    mode_e              mode_s1;
    logic [TAG_W-1:0]   tag_s1;
    logic               apx_sel;

    logic [NT*NT-1:0][TP-1:0] tiles_d;

    logic                     valid_s2;
    logic [NT*NT-1:0][TP-1:0] tiles_s2;
    logic                     or_s2;
    logic [TAG_W-1:0]         tag_s2;

    logic [PW-1:0] term;
    logic [PW-1:0] sum_r;
    logic [PW-1:0] or_r;
    logic [PW-1:0] comb_r;

    // Whole pipeline freezes while a result sits unaccepted at the output
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1 <= 1'b0;
        end else if (adv) begin
            valid_s1 <= in_valid;
            if (in_valid) begin
                a_s1    <= in_a;
                b_s1    <= in_b;
                mode_s1 <= (in_mode == 2'b11) ? MODE_EXACT : mode_e'(in_mode);
                tag_s1  <= in_tag;
            end
        end
    end

    assign apx_sel = (mode_s1 != MODE_EXACT);

    // Only tiles in the low-significance triangle (i+j < NT) may be approximated
    for (genvar gi = 0; gi < NT; gi++) begin : g_row
        for (genvar gj = 0; gj < NT; gj++) begin : g_col
            sub_mult_4x4 #(
                .TRUNC(TRUNC)
            ) u_tile (
                .a      (a_s1[SUB_W*gi +: SUB_W]),
                .b      (b_s1[SUB_W*gj +: SUB_W]),
                .apx_en (apx_sel && ((gi + gj) < NT)),
                .p      (tiles_d[gi*NT + gj])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s2 <= 1'b0;
        end else if (adv) begin
            valid_s2 <= valid_s1;
            if (valid_s1) begin
                tiles_s2 <= tiles_d;
                or_s2    <= (mode_s1 == MODE_APX_OR);
                tag_s2   <= tag_s1;
            end
        end
    end

    always_comb begin
        term  = '0;
        sum_r = '0;
        or_r  = '0;
        for (int k = 0; k < NT*NT; k++) begin
            term  = PW'(tiles_s2[k]) << (SUB_W * ((k / NT) + (k % NT)));
            sum_r = sum_r + term;
            or_r  = or_r | term;
        end
        comb_r = or_s2 ? or_r : sum_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= valid_s2;
            if (valid_s2) begin
                out_r   <= comb_r;
                out_tag <= tag_s2;
            end
        end
    end

`ifdef APPROX_MULT_ERRSTAT_EN
    logic [PW-1:0] exact_s2;
    logic          err_s3;

    // Exact reference rides alongside the tile products
    always_ff @(posedge clk) begin
        if (rst) begin
            exact_s2 <= '0;
            err_s3   <= 1'b0;
        end else if (adv) begin
            if (valid_s1) begin
                exact_s2 <= PW'(a_s1) * PW'(b_s1);
            end
            if (valid_s2) begin
                err_s3 <= (comb_r != exact_s2);
            end
        end
    end

    assign out_err = out_valid && err_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err_s3 && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined approximate multiplier. Splits WIDTH x WIDTH operands into 4x4 tiles and feeds each tile to an exact or truncated 4x4 sub-multiplier.
- Recombines tile products by exact addition or by column-wise OR, selected per transaction.
- Valid/ready streaming handshake with a sideband tag. Sits between operand FIFOs and accuracy-tolerant datapaths (filters, NN MACs).

Parameters:
- WIDTH, 8, operand width; multiple of 4, legal 8..16; NT = WIDTH/4 tiles per operand.
- TRUNC, 2, low product bits forced to 0 in an approximate 4x4 tile; legal 0..4.
- TAG_W, 4, sideband tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  unsigned multiplicand.
- in_b  in  WIDTH  unsigned multiplier.
- in_mode  in  2  00 exact; 01 approx-low tiles + add; 10 approx-low tiles + OR combine; 11 treated as 00.
- in_tag  in  TAG_W  opaque tag, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_r  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Tiles: A_i = in_a[4i+3:4i], B_j = in_b[4j+3:4j]; P_ij = sub(A_i, B_j) << 4(i+j).
- Tile (i,j) is "low" iff i+j < NT. Modes 01/10 use the approx sub-multiplier for low tiles and exact for the rest; mode 00/11 uses exact for all tiles.
- Approx 4x4: (a*b) with bits [TRUNC-1:0] cleared. Exact 4x4: a*b, 8 bits.
- Combine: modes 00/01/11 = sum of all P_ij modulo 2^(2*WIDTH), no overflow possible. Mode 10 = bitwise OR of all P_ij.
- Pipeline, 3 register stages:
  - S1: captures a, b, mode, tag on in_valid && in_ready.
  - S2: registers all NT*NT tile products.
  - S3: registers the combined result to out_r/out_tag.
- Latency: 3 cycles from accept to out_valid with no backpressure. Throughput: 1 beat/cycle.
- Stall rule: adv = !out_valid || out_ready. All stages advance only when adv=1; in_ready = adv && !rst.
- Per-stage valid bits shift with adv. Bubbles propagate as valid=0, and bubbles are not compressed.
- While out_valid=1 && out_ready=0: out_r and out_tag are held stable and no stage advances.
- in_valid=1 while in_ready=0: the beat is not taken; upstream holds it.
- Simultaneous accept and output in the same cycle is legal; no data is lost or duplicated.
- Reset (any cycle, including mid-stream): all stage valids, out_valid, out_r and out_tag go to 0; in-flight beats are dropped; in_ready = 0 during reset and 1 on the first cycle after reset.
- Elaboration-time check: WIDTH%4 != 0 or TRUNC > 4 triggers $error.

Optional Feature:
- Macro: APPROX_MULT_ERRSTAT_EN.
- Defined:
  - Adds an exact reference product computed in parallel through S2/S3.
  - Adds out_err (out, 1): high with out_valid when out_r != exact.
  - Adds err_cnt (out, 16): saturating count of emitted beats with out_err=1. Counts only on the out_valid && out_ready handshake. Cleared by rst. Holds at 0xFFFF.
- Undefined: neither port exists; no extra logic is generated.

Decomposition:
- Package approx_mult_pkg:
  - mode enum (MODE_EXACT, MODE_APX_ADD, MODE_APX_OR).
  - SUB_W = 4.
  - Function apx4(a, b, trunc).
- Sub-module sub_mult_4x4: inputs a[3:0], b[3:0], apx_en; output p[7:0]. Purely combinational. Instantiated NT*NT times in a generate loop between S1 and S2.

Test Plan:
- Exact mode: WIDTH=8, a=0xFF, b=0xFF, mode=00 -> out_r=0xFE01 exactly 3 cycles after accept; tag echoed.
- Approx-add mode: WIDTH=8, TRUNC=2, a=0xFF, b=0xFF, mode=01 -> out_r=0xFDE0; with macro, out_err=1 and err_cnt increments to 1.
- OR mode: same operands, mode=10 -> out_r=0xEFE0. Mode 11 with a=0x12, b=0x34 -> 0x03A8.
- Backpressure: stream 5 beats (a=0x12, b=0x34, tags 0..4) with out_ready low for 4 cycles mid-stream -> out_r and out_tag held stable, in_ready=0 while stalled, all 5 results (0x03A8) delivered in tag order, none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale results emitted afterward, in_ready=1 the cycle after reset deasserts.
- Width sweep: WIDTH=16, TRUNC=0 with random operands in all modes -> mode 00 equals a*b. Modes 01/10 match the package reference model bit-exactly over 10k beats.
